regfile_dump_unit: RTL and testbench

Debug read-out engine for the 32-entry register file. On a start pulse it walks a programmed index range through one register-file read port. Each register value is captured and streamed out over a valid/ready handshake, tagged with its index. It sits beside the datapath and drives the read address when the debug mux selects it; it never writes the register file.

---
 rtl/rf_dbg_pkg.sv | 14 +
 rtl/regfile_dump_unit.sv | 104 ++++++++++
 tb/tb_regfile_dump_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/rf_dbg_pkg.sv
// Shared types and sizes for the register-file debug dump logic.
package rf_dbg_pkg;

    localparam int REG_COUNT = 32;
    localparam int IDX_W     = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_unit.sv
// Debug read-out engine: walks an index range of the register file through
// one read port and streams each captured value out over valid/ready.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; rf_addr holds the last index walked
// READ  | rf_addr = cur, value captured into the output register
// SEND  | beat presented on dout_*, held until dout_ready
// DONE  | one-cycle done pulse, then back to IDLE
import rf_dbg_pkg::*;

module regfile_dump_unit #(
    parameter int N_Bits = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IDX_W-1:0]  first_idx,
    input  logic [IDX_W-1:0]  last_idx,
    input  logic              abort,
    output logic [IDX_W-1:0]  rf_addr,
    input  logic [N_Bits-1:0] rf_data,
    output logic [N_Bits-1:0] dout_data,
    output logic [IDX_W-1:0]  dout_idx,
    output logic              dout_last,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              done
);

    dump_state_t      state;
    logic [IDX_W-1:0] cur;
    logic [IDX_W-1:0] last;

    // The read port is driven straight from the index counter in every state.
    assign rf_addr = cur;

    // Sequencer, index counter and output holding register in one block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cur        <= '0;
            last       <= '0;
            dout_data  <= '0;
            dout_idx   <= '0;
            dout_last  <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        cur   <= first_idx;
                        last  <= last_idx;
                        busy  <= 1'b1;
                        state <= READ;
                    end
                end
                READ: begin
                    if (abort) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        dout_data  <= rf_data;
                        dout_idx   <= cur;
                        dout_last  <= (cur == last);
                        dout_valid <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    // Abort wins over a coincident handshake: the beat is dropped.
                    if (abort) begin
                        dout_valid <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end else if (dout_ready) begin
                        dout_valid <= 1'b0;
                        if (dout_last) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            cur   <= cur + 1'b1;
                            state <= READ;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Directed bench for regfile_dump_unit with a behavioural register file.
module tb_regfile_dump_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  first_idx = '0;
    logic [4:0]  last_idx = '0;
    logic        abort = 1'b0;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [31:0] dout_data;
    logic [4:0]  dout_idx;
    logic        dout_last;
    logic        dout_valid;
    logic        dout_ready = 1'b1;
    logic        busy;
    logic        done;

    logic [31:0] rf     [32];
    logic [31:0] golden [32];

    int checks = 0;
    int errors = 0;

    regfile_dump_unit #(.N_Bits(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .first_idx  (first_idx),
        .last_idx   (last_idx),
        .abort      (abort),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .dout_data  (dout_data),
        .dout_idx   (dout_idx),
        .dout_last  (dout_last),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    assign rf_data = (rf_addr == 5'd0) ? 32'd0 : rf[rf_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one dump from f to l; inputs change and outputs are sampled at negedge.
    task automatic run_dump(input logic [4:0] f, input logic [4:0] l,
                            input int stall_idx, input int stall_len,
                            input bit do_abort, input bit wr_hook, input bit spam,
                            output int beats, output int last_hs_cyc);
        int         cyc;
        int         stalled;
        int         exp_v;
        bit         fin;
        logic [4:0] exp_idx;
        start = 1'b1; first_idx = f; last_idx = l; dout_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_read", {31'd0, busy}, 32'd1);
        exp_idx = f; beats = 0; stalled = 0; fin = 1'b0; cyc = 0;
        last_hs_cyc = -1; exp_v = 0;
        while (!fin && cyc < 400) begin
            start = 1'b0;
            if (exp_v >= 0) check("valid_seq", {31'd0, dout_valid}, exp_v);
            check("no_early_done", {31'd0, done}, 32'd0);
            if (dout_valid) begin
                check("idx", {27'd0, dout_idx}, {27'd0, exp_idx});
                check("data", dout_data, golden[exp_idx]);
                check("last", {31'd0, dout_last}, {31'd0, exp_idx == l});
                if (wr_hook && exp_idx == 5'd3) begin
                    rf[10] = 32'hDEAD;
                    rf[2]  = 32'hBEEF;
                end
                if (spam && beats == 2) begin
                    start = 1'b1; first_idx = 5'd20; last_idx = 5'd20;
                end
                if (int'(exp_idx) == stall_idx && stalled < stall_len) begin
                    dout_ready = 1'b0;
                    stalled++;
                    exp_v = 1;
                    if (do_abort && stalled == 2) begin
                        abort = 1'b1;
                        fin = 1'b1;
                    end
                end else begin
                    dout_ready = 1'b1;
                    beats++;
                    last_hs_cyc = cyc;
                    exp_v = 0;
                    if (exp_idx == l) fin = 1'b1;
                    exp_idx = exp_idx + 5'd1;
                end
            end else begin
                check("rf_addr", {27'd0, rf_addr}, {27'd0, exp_idx});
                exp_v = 1;
            end
            @(negedge clk);
            cyc++;
        end
        abort = 1'b0; dout_ready = 1'b1; start = 1'b0;
        if (!fin) check("timeout", 32'd0, 32'd1);
        check("done_pulse", {31'd0, done}, 32'd1);
        check("valid_after", {31'd0, dout_valid}, 32'd0);
        check("busy_in_done", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("done_clr", {31'd0, done}, 32'd0);
        check("busy_clr", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int beats;
        int hs;
        for (int i = 0; i < 32; i++) begin
            rf[i]     = (i == 0) ? 32'd0 : 32'h100 + i;
            golden[i] = rf[i];
        end
        #1;
        check("rst_rf_addr", {27'd0, rf_addr}, 32'd0);
        check("rst_data", dout_data, 32'd0);
        check("rst_idx", {27'd0, dout_idx}, 32'd0);
        check("rst_last", {31'd0, dout_last}, 32'd0);
        check("rst_valid", {31'd0, dout_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full dump, ready high: 32 beats, final handshake 64 cycles after READ entry.
        run_dump(5'd0, 5'd31, -1, 0, 1'b0, 1'b0, 1'b0, beats, hs);
        check("full_beats", beats, 32);
        check("full_cycles", hs + 1, 64);

        // Backpressure on beat 4.
        run_dump(5'd0, 5'd8, 4, 3, 1'b0, 1'b0, 1'b0, beats, hs);
        check("bp_beats", beats, 9);

        // Wrap through 31 to 0, and a single-beat range.
        run_dump(5'd30, 5'd1, -1, 0, 1'b0, 1'b0, 1'b0, beats, hs);
        check("wrap_beats", beats, 4);
        run_dump(5'd7, 5'd7, -1, 0, 1'b0, 1'b0, 1'b0, beats, hs);
        check("single_beats", beats, 1);

        // Writes while cur = 3: x10 visible, x2 already captured.
        golden[10] = 32'hDEAD;
        run_dump(5'd0, 5'd12, -1, 0, 1'b0, 1'b1, 1'b0, beats, hs);
        check("wr_beats", beats, 13);
        golden[2] = 32'hBEEF;

        // Start while busy has no effect.
        run_dump(5'd0, 5'd5, -1, 0, 1'b0, 1'b0, 1'b1, beats, hs);
        check("spam_beats", beats, 6);

        // Abort while beat 6 is stalled.
        run_dump(5'd0, 5'd10, 6, 5, 1'b1, 1'b0, 1'b0, beats, hs);
        check("abort_beats", beats, 6);

        // Abort in IDLE is ignored.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort_done", {31'd0, done}, 32'd0);
        check("idle_abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("idle_abort_done2", {31'd0, done}, 32'd0);

        // Reset while a beat is pending.
        start = 1'b1; first_idx = 5'd0; last_idx = 5'd31;
        @(negedge clk);
        start = 1'b0; dout_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", {31'd0, dout_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, dout_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_addr", {27'd0, rf_addr}, 32'd0);
        check("mid_rst_data", dout_data, 32'd0);
        check("mid_rst_idx", {27'd0, dout_idx}, 32'd0);
        check("mid_rst_last", {31'd0, dout_last}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; dout_ready = 1'b1;
        @(negedge clk);
        check("post_rst_done", {31'd0, done}, 32'd0);
        run_dump(5'd28, 5'd2, -1, 0, 1'b0, 1'b0, 1'b0, beats, hs);
        check("post_rst_beats", beats, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
